// File: rtl/fxp_pkg.sv
// Shared widths, saturation bounds and Q-format lane type for the fixed-point MAC.
// The default format is Q24.8; FXP_MAC_ROUND_EN is the build option that selects round-half-up scaling.
package fxp_pkg;

  localparam int unsigned IW_DEF        = 24;
  localparam int unsigned FW_DEF        = 8;
  localparam int unsigned LANES_DEF     = 4;
  localparam int unsigned ACC_GUARD_DEF = 8;

  localparam int unsigned W_DEF = IW_DEF + FW_DEF;
  localparam int unsigned P_DEF = 2 * W_DEF;
  localparam int unsigned A_DEF = P_DEF + ACC_GUARD_DEF;

  localparam logic signed [W_DEF-1:0] Q_MAX = {1'b0, {(W_DEF-1){1'b1}}};
  localparam logic signed [W_DEF-1:0] Q_MIN = {1'b1, {(W_DEF-1){1'b0}}};

  typedef logic signed [W_DEF-1:0] q_t;

endpackage

// File: rtl/fxp_mac_lane.sv
// One MAC lane: registered product, running accumulator, scale and saturate to W bits.
// When FXP_MAC_ROUND_EN is defined, half an output LSB is added before the fraction shift.
module fxp_mac_lane
  import fxp_pkg::*;
#(
  parameter int unsigned IW        = IW_DEF,
  parameter int unsigned FW        = FW_DEF,
  parameter int unsigned ACC_GUARD = ACC_GUARD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               fold_i,
  input  logic               zero_base_i,
  input  logic               load_i,
  input  logic [IW+FW-1:0]   fmap_i,
  input  logic [IW+FW-1:0]   wht_i,
  output logic [IW+FW-1:0]   res_o,
  output logic               sat_o
);

  localparam int unsigned W = IW + FW;
  localparam int unsigned P = 2 * W;
  localparam int unsigned A = P + ACC_GUARD;

  // Result bounds sign-extended to the scaled accumulator width
  localparam logic signed [A:0] R_MAX = {{(A-W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [A:0] R_MIN = {{(A-W+2){1'b1}}, {(W-1){1'b0}}};
`ifdef FXP_MAC_ROUND_EN
  localparam logic [A:0] HALF = {{A{1'b0}}, 1'b1} << (FW - 1);
`endif

  logic signed [P-1:0] prod_q, prod_d;
  logic [A-1:0]        acc_q, acc_d;
  logic [A:0]          acc_x;
  logic signed [A:0]   scaled;
  logic [W-1:0]        res_q, res_d;
  logic                sat_q, sat_d;

  always_comb begin
    prod_d = P'($signed(fmap_i)) * P'($signed(wht_i));
    acc_d  = (zero_base_i ? '0 : acc_q) + {{ACC_GUARD{prod_q[P-1]}}, prod_q};
    // One extra MSB keeps the rounding add from wrapping
    acc_x  = {acc_q[A-1], acc_q};
`ifdef FXP_MAC_ROUND_EN
    acc_x  = acc_x + HALF;
`endif
    scaled = $signed(acc_x) >>> FW;
    res_d  = scaled[W-1:0];
    sat_d  = 1'b0;
    if (scaled > R_MAX) begin
      res_d = R_MAX[W-1:0];
      sat_d = 1'b1;
    end else if (scaled < R_MIN) begin
      res_d = R_MIN[W-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      acc_q  <= '0;
      res_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      if (en_i)   prod_q <= prod_d;
      if (fold_i) acc_q  <= acc_d;
      if (load_i) begin
        res_q <= res_d;
        sat_q <= sat_d;
      end
    end
  end

  assign res_o = res_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/fxp_mac.sv
// Multi-lane fixed-point multiply-accumulate with a 3-stage pipeline and a result handshake.
// Lanes share one valid/enable control path; the whole pipeline stalls while a result is held.
module fxp_mac
  import fxp_pkg::*;
#(
  parameter int unsigned IW        = IW_DEF,
  parameter int unsigned FW        = FW_DEF,
  parameter int unsigned LANES     = LANES_DEF,
  parameter int unsigned ACC_GUARD = ACC_GUARD_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_first,
  input  logic                        in_last,
  input  logic [LANES*(IW+FW)-1:0]    fmap,
  input  logic [LANES*(IW+FW)-1:0]    wht,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*(IW+FW)-1:0]    res,
  output logic [LANES-1:0]            sat_flag
);

  localparam int unsigned W = IW + FW;

  logic en, fold, zero_base, load;
  logic s1_valid_q, s1_valid_d;
  logic s1_first_q, s1_first_d;
  logic s1_last_q,  s1_last_d;
  logic clr_q,      clr_d;
  logic s2_last_q,  s2_last_d;
  logic out_valid_q, out_valid_d;

  // clr_q remembers that the last folded beat closed a set, so the next one starts from zero
  always_comb begin
    en          = !(out_valid_q && !out_ready);
    in_ready    = en;
    fold        = en && s1_valid_q;
    zero_base   = s1_first_q || clr_q;
    load        = en && s2_last_q;
    s1_valid_d  = s1_valid_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    clr_d       = clr_q;
    s2_last_d   = s2_last_q;
    out_valid_d = out_valid_q;
    if (en) begin
      s1_valid_d  = in_valid;
      s1_first_d  = in_valid && in_first;
      s1_last_d   = in_valid && in_last;
      s2_last_d   = s1_valid_q && s1_last_q;
      out_valid_d = s2_last_q;
      if (s1_valid_q) clr_d = s1_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      clr_q       <= 1'b0;
      s2_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      clr_q       <= clr_d;
      s2_last_q   <= s2_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fxp_mac_lane #(
      .IW        (IW),
      .FW        (FW),
      .ACC_GUARD (ACC_GUARD)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .en_i        (en),
      .fold_i      (fold),
      .zero_base_i (zero_base),
      .load_i      (load),
      .fmap_i      (fmap[g*W +: W]),
      .wht_i       (wht[g*W +: W]),
      .res_o       (res[g*W +: W]),
      .sat_o       (sat_flag[g])
    );
  end

endmodule

// File: tb/tb_fxp_mac.sv
// Bench for fxp_mac in Q24.8 with 4 lanes: vector table plus multi-cycle sequences, scoreboard-checked.
// Expected rounding results follow FXP_MAC_ROUND_EN.
module tb_fxp_mac;
  import fxp_pkg::*;

  localparam int unsigned LANES = 4;
  localparam int unsigned W     = 32;
  localparam int unsigned LW    = LANES * W;

`ifdef FXP_MAC_ROUND_EN
  localparam logic [31:0] R_HALF  = 32'h1;
  localparam logic [31:0] R_NHALF = 32'h0;
  localparam logic [31:0] R_1P5   = 32'h2;
`else
  localparam logic [31:0] R_HALF  = 32'h0;
  localparam logic [31:0] R_NHALF = 32'hFFFFFFFF;
  localparam logic [31:0] R_1P5   = 32'h1;
`endif

  typedef struct {
    logic [LW-1:0]    res;
    logic [LANES-1:0] sat;
  } exp_t;

  typedef struct {
    logic [LW-1:0]    fm;
    logic [LW-1:0]    wt;
    logic [LW-1:0]    res;
    logic [LANES-1:0] sat;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             in_valid, in_ready, in_first, in_last;
  logic [LW-1:0]    fmap, wht, res;
  logic             out_valid, out_ready;
  logic [LANES-1:0] sat_flag;

  exp_t sbq[$];
  vec_t vt[4];
  int   checks, errors, n_out;

  fxp_mac dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_last   (in_last),
    .fmap      (fmap),
    .wht       (wht),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .sat_flag  (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LW-1:0] p4(input q_t a, input q_t b, input q_t c, input q_t d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst && out_valid && out_ready) begin
        n_out++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out res=%h required no output", res);
        end else begin
          e = sbq.pop_front();
          chk("res", res, e.res);
          chk("sat_flag", LW'(sat_flag), LW'(e.sat));
        end
      end
    end
  endtask

  // Present a beat at the negedge and hold it until the DUT accepts it
  task automatic send(input logic f, input logic l, input logic [LW-1:0] fm, input logic [LW-1:0] wt,
                      input logic [LW-1:0] er, input logic [LANES-1:0] es);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    fmap     = fm;
    wht      = wt;
    #4;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #4;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
    end else if (l) begin
      e.res = er;
      e.sat = es;
      sbq.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", sbq.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [LW-1:0] ones, ramp;
    time           t0, t1;
    checks = 0; errors = 0; n_out = 0;
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    fmap = '0; wht = '0; out_ready = 1'b1;
    ones = p4(32'h100, 32'h100, 32'h100, 32'h100);
    ramp = p4(32'h100, 32'h200, 32'h300, 32'h400);

    vt[0] = '{fm: p4(32'h180, 32'h100, 32'hFFFFFF00, Q_MAX),
              wt: p4(32'h200, 32'h100, 32'h200, Q_MAX),
              res: p4(32'h300, 32'h100, 32'hFFFFFE00, Q_MAX), sat: 4'b1000};
    vt[1] = '{fm: p4(32'h80000001, 32'h1, 32'hFFFFFF80, 32'h0),
              wt: p4(Q_MAX, 32'h80, 32'h300, 32'h12345),
              res: p4(Q_MIN, R_HALF, 32'hFFFFFE80, 32'h0), sat: 4'b0001};
    vt[2] = '{fm: p4(32'hFFFFFFFF, 32'h10000, 32'h800000, 32'hFF800000),
              wt: p4(32'h80, 32'h10000, 32'h10000, 32'h10000),
              res: p4(R_NHALF, 32'h01000000, Q_MAX, Q_MIN), sat: 4'b0100};
    vt[3] = '{fm: p4(32'h3, Q_MAX, Q_MIN, Q_MIN),
              wt: p4(32'h80, 32'h100, 32'h100, 32'hFFFFFF00),
              res: p4(R_1P5, Q_MAX, Q_MIN, Q_MAX), sat: 4'b1000};

    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_out_valid", LW'(out_valid), LW'(0));
    chk("rst_res", res, '0);
    chk("rst_sat", LW'(sat_flag), LW'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", LW'(in_ready), LW'(1));

    // Single-beat vectors back to back
    for (int i = 0; i < 4; i++) send(1'b1, 1'b1, vt[i].fm, vt[i].wt, vt[i].res, vt[i].sat);
    idle();
    drain();

    // Latency from accepted last beat to out_valid
    send(1'b1, 1'b1, p4(32'h180, 32'h0, 32'h0, 32'h0), p4(32'h200, 32'h0, 32'h0, 32'h0),
         p4(32'h300, 32'h0, 32'h0, 32'h0), 4'b0000);
    idle();
    chk("lat_cycle1", LW'(out_valid), LW'(0));
    @(negedge clk);
    chk("lat_cycle2", LW'(out_valid), LW'(0));
    @(negedge clk);
    chk("lat_cycle3", LW'(out_valid), LW'(1));
    drain();

    // Four beats with bubbles, then a set that begins without in_first
    n_out = 0;
    send(1'b1, 1'b0, ramp, ones, '0, '0);
    idle();
    repeat (2) @(negedge clk);
    send(1'b0, 1'b0, ramp, ones, '0, '0);
    send(1'b0, 1'b0, ramp, ones, '0, '0);
    send(1'b0, 1'b1, ramp, ones, p4(32'h400, 32'h800, 32'hC00, 32'h1000), 4'b0000);
    idle();
    drain();
    chk("one_pulse", LW'(n_out), LW'(1));
    send(1'b0, 1'b1, ramp, ones, ramp, 4'b0000);
    idle();
    drain();

    // Back-pressure: hold out_ready low for 5 cycles once a result is up
    out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 4; k++)
          send(1'b1, 1'b1, p4(32'(k*256), 32'((k+1)*256), 32'((k+2)*256), 32'((k+3)*256)), ones,
               p4(32'(k*256), 32'((k+1)*256), 32'((k+2)*256), 32'((k+3)*256)), 4'b0000);
        idle();
      end
      begin
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("bp_valid_seen", LW'(out_valid), LW'(1));
        repeat (5) begin
          @(negedge clk);
          chk("bp_res_hold", res, ramp);
          chk("bp_in_ready", LW'(in_ready), LW'(0));
          chk("bp_valid_hold", LW'(out_valid), LW'(1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Throughput: six beats on consecutive cycles
    for (int k = 0; k < 6; k++) begin
      send(k == 0, k == 5, ones, ones, p4(32'h600, 32'h600, 32'h600, 32'h600), 4'b0000);
      if (k == 0) t0 = $time;
      if (k == 5) t1 = $time;
    end
    idle();
    drain();
    chk("throughput", LW'(t1 - t0), LW'(50));

    // Reset in the middle of a set; the partial sum must be gone
    send(1'b1, 1'b0, ones, ones, '0, '0);
    send(1'b0, 1'b0, ones, ones, '0, '0);
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_res", res, '0);
    chk("mid_rst_valid", LW'(out_valid), LW'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", LW'(in_ready), LW'(1));
    send(1'b0, 1'b1, ones, ones, ones, 4'b0000);
    send(1'b1, 1'b1, ones, ones, ones, 4'b0000);
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fxp_mac.md
FXP_MAC -- requirements
Module: fxp_mac

Interface
REQ-001 Parameter IW, default 24, integer bits of every signed fixed-point operand and result.
REQ-002 Parameter FW, default 8, fraction bits; operand/result width W = IW+FW.
REQ-003 Parameter LANES, default 4, number of independent parallel multiply-accumulate lanes.
REQ-004 Parameter ACC_GUARD, default 8, extra accumulator MSBs; accumulator width A = 2W+ACC_GUARD.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  input beat present.
REQ-008 in_ready  output  1  block accepts beat this cycle.
REQ-009 in_first  input  1  beat starts a new accumulation.
REQ-010 in_last  input  1  beat ends the accumulation; produces one result.
REQ-011 fmap  input  LANES*W  signed feature-map operands, lane 0 in LSBs.
REQ-012 wht  input  LANES*W  signed weight operands, lane 0 in LSBs.
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 res  output  LANES*W  signed fixed-point results, lane 0 in LSBs.
REQ-016 sat_flag  output  LANES  per-lane: result was saturated.

Function
REQ-017 Beat accepted when in_valid && in_ready; in_first/in_last sampled only on accepted beats.
REQ-018 Pipeline enable en = !(out_valid && !out_ready); in_ready = en; all stages advance only when en.
REQ-019 Stage 1 registers full 2W-bit signed product fmap*wht per lane.
REQ-020 Stage 2: in_first -> acc = sign-extended product; else acc = acc + product; A-bit two's-complement, wraps on overflow.
REQ-021 Accumulator cleared to 0 after an in_last beat is folded; next beat without in_first accumulates from 0.
REQ-022 in_first and in_last on same beat -> single-product result.
REQ-023 Stage 3 on in_last: scale acc arithmetic right by FW, saturate to W-bit signed range [-2^(W-1), 2^(W-1)-1], set sat_flag if clamped; register res, set out_valid.
REQ-024 Latency: accepted in_last beat -> out_valid exactly 3 cycles later with no back-pressure.
REQ-025 res, sat_flag, out_valid hold stable while out_valid && !out_ready.
REQ-026 Throughput one beat per cycle while out_ready held high; non-last beats never assert out_valid.
REQ-027 Bubbles (in_valid low) preserve accumulator contents.

Reset
REQ-028 rst clears out_valid, res, sat_flag, all stage valids and accumulators to 0; in_ready 1 from the cycle after rst deasserts.
REQ-029 rst mid-accumulation discards partial sums; no output produced for the aborted set.

Configuration
REQ-030 FXP_MAC_ROUND_EN defined: add 2^(FW-1) to acc before the FW shift (round half up), then saturate.
REQ-031 FXP_MAC_ROUND_EN undefined: plain truncating arithmetic shift (floor); no adder present.

Structure
REQ-032 Package fxp_pkg holds W-derived widths, saturation min/max constants, and the Q-format lane typedef.
REQ-033 Sub-module fxp_mac_lane implements one lane (stages 1-3 datapath); fxp_mac instantiates LANES copies plus shared valid/enable control.

Verification (IW=24, FW=8)
REQ-034 Single beat, first+last, fmap=0x180 (1.5), wht=0x200 (2.0) -> res=0x300, sat_flag=0, out_valid 3 cycles later.
REQ-035 Four beats first..last, each 0x100*0x100 -> res=0x400 (4.0), one out_valid pulse only.
REQ-036 fmap=0x7FFFFFFF, wht=0x7FFFFFFF, first+last -> res=0x7FFFFFFF, sat_flag=1; negated fmap -> res=0x80000000, sat_flag=1.
REQ-037 fmap=0x001, wht=0x080 (product 0.5 LSB) -> res=0x001 with FXP_MAC_ROUND_EN, 0x000 without.
REQ-038 out_ready low 5 cycles while out_valid -> res stable, in_ready low, no beat lost; resumes at one beat/cycle.
REQ-039 rst pulsed after 2 of 4 beats, then a fresh first+last 0x100*0x100 -> res=0x100, no stale output.
